register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter DATA_W, default 32: width of every register and data port.
REQ-002 Parameter SP_INIT, default 227: reset value of register 29 (stack pointer).
REQ-003 Parameter BYPASS, default 1: 1 enables same-cycle write-to-read forwarding; 0 disables it.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 reg_write  input  1  write enable from control unit.
REQ-007 read_reg1  input  5  read port 1 address (instruction[25:21]).
REQ-008 read_reg2  input  5  read port 2 address (instruction[20:16]).
REQ-009 write_reg  input  5  write address, driven by the write-register select mux (rt, 29, 31 or rd).
REQ-010 write_data  input  DATA_W  data to write.
REQ-011 read_data1  output  DATA_W  contents of register read_reg1.
REQ-012 read_data2  output  DATA_W  contents of register read_reg2.

Function
REQ-013 Storage: 32 registers, each DATA_W bits, indexed 0..31.
REQ-014 Write: on rising clk with reset=1, reg_write=1 and write_reg!=0, register[write_reg] SHALL take write_data; visible to reads after that edge (1-cycle write latency).
REQ-015 reg_write=0: no register SHALL change on the edge.
REQ-016 Register 0: writes SHALL be ignored; read_data1/2 SHALL be 0 whenever the corresponding address is 0, regardless of BYPASS.
REQ-017 Reads: combinational, zero latency; read_dataN = register[read_regN] in the same cycle the address is applied.
REQ-018 Bypass (BYPASS=1): when reg_write=1, write_reg!=0 and write_reg==read_regN, read_dataN SHALL equal write_data in the same cycle, before the edge.
REQ-019 Bypass off (BYPASS=0): read_dataN SHALL show the old register value until the write edge.
REQ-020 Both read ports may address the same register simultaneously; both SHALL return identical values.
REQ-021 Writes to 29 and 31 (from the select mux for push/pop and jal) SHALL behave like any other non-zero register; a write to 29 overrides SP_INIT.
REQ-022 Back-to-back writes to the same register on consecutive edges: last write wins, each visible one cycle after its edge.
REQ-023 No X propagation: every register SHALL hold a defined value after reset.

Reset
REQ-024 reset=0 SHALL immediately, independent of clk, force register 29 to SP_INIT and all other registers to 0.
REQ-025 During reset, read_data1/2 SHALL reflect the reset contents (0, or SP_INIT for address 29), with bypass suppressed.
REQ-026 Reset asserted on the same edge as a write: reset wins; the write SHALL be lost.
REQ-027 After reset deassertion, the first write SHALL occur no earlier than the next rising clk edge.

Verification
REQ-028 Reset: reset=0, read_reg1=29, read_reg2=5 -> read_data1=227, read_data2=0 with no clock edge.
REQ-029 Write/read: reg_write=1, write_reg=8, write_data=0xDEADBEEF, one edge; then read_reg1=8 -> read_data1=0xDEADBEEF; reg_write=0, write_data=0x1 plus edge -> still 0xDEADBEEF.
REQ-030 Register 0: write_reg=0, write_data=0xFFFFFFFF, reg_write=1, edge; read_reg1=read_reg2=0 -> both 0.
REQ-031 Bypass: BYPASS=1, reg 9 holds 0x5, reg_write=1, write_reg=9, write_data=0xA, read_reg2=9 before edge -> read_data2=0xA; with BYPASS=0 -> 0x5 before edge, 0xA after.
REQ-032 jal/stack targets: write 0x400 to 31, then 0xE0 to 29 on consecutive edges -> read 31=0x400, read 29=0xE0; assert reset -> 29=227, 31=0.
REQ-033 Reset mid-write: reg 3 holds 0x7; reset=0 coincident with write of 0x9 to 3 -> reg 3=0 after reset release, not 0x9.

Source files
------------

// File: rtl/register_bank.sv
// register_bank: 32 x DATA_W general-purpose register file with two
// combinational read ports and one synchronous write port.
//
// Register 0 always reads as zero and ignores writes. Register 29 (stack
// pointer) resets to SP_INIT, and all other registers reset to zero. When BYPASS
// is set, a pending write is forwarded to a read port that addresses the
// same register in the same cycle.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   reg_write   in   write enable
//   read_reg1   in   [4:0]        read port 1 address
//   read_reg2   in   [4:0]        read port 2 address
//   write_reg   in   [4:0]        write address
//   write_data  in   [DATA_W-1:0] write data
//   read_data1  out  [DATA_W-1:0] contents of read_reg1
//   read_data2  out  [DATA_W-1:0] contents of read_reg2

module register_bank #(
    parameter int DATA_W  = 32,
    parameter int SP_INIT = 227,
    parameter bit BYPASS  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam logic [4:0]        SP_ADDR  = 5'd29;
    localparam logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_INIT);

    logic [DATA_W-1:0] r_regs [32];

    logic w_wr_en;
    logic w_fwd1;
    logic w_fwd2;

    // Writes to register 0 are dropped here, so storage for it is never
    // updated; reads of address 0 are also forced to zero below.
    assign w_wr_en = reg_write && (write_reg != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= (5'(i) == SP_ADDR) ? SP_RESET : '0;
            end
        end else if (w_wr_en) begin
            r_regs[write_reg] <= write_data;
        end
    end

    // Forwarding is gated by reset so reads during reset show reset contents.
    assign w_fwd1 = BYPASS && reset && w_wr_en && (write_reg == read_reg1);
    assign w_fwd2 = BYPASS && reset && w_wr_en && (write_reg == read_reg2);

    always_comb begin
        read_data1 = r_regs[read_reg1];
        if (read_reg1 == 5'd0) begin
            read_data1 = '0;
        end else if (w_fwd1) begin
            read_data1 = write_data;
        end
    end

    always_comb begin
        read_data2 = r_regs[read_reg2];
        if (read_reg2 == 5'd0) begin
            read_data2 = '0;
        end else if (w_fwd2) begin
            read_data2 = write_data;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Testbench for register_bank. Two instances share all inputs: one with
// forwarding enabled and one with it disabled. A behavioural array model
// gives the expected read values, and directed literal checks pin that model.

module tb_register_bank;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    logic [31:0] m_regs [32];

    register_bank #(.DATA_W(32), .SP_INIT(227), .BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .reg_write(reg_write),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data),
        .read_data1(rd1_b), .read_data2(rd2_b)
    );

    register_bank #(.DATA_W(32), .SP_INIT(227), .BYPASS(1'b0)) dut_n (
        .clk(clk), .reset(reset), .reg_write(reg_write),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data),
        .read_data1(rd1_n), .read_data2(rd2_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? 32'd227 : 32'd0;
    endtask

    initial model_reset();

    always @(negedge reset) model_reset();

    always @(posedge clk) begin
        if (reset === 1'b1 && reg_write === 1'b1 && write_reg != 5'd0)
            m_regs[write_reg] <= write_data;
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && reset && reg_write && write_reg == a) return write_data;
        return m_regs[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_rd1_bypass", rd1_b, exp_rd(read_reg1, 1'b1));
            chk("model_rd2_bypass", rd2_b, exp_rd(read_reg2, 1'b1));
            chk("model_rd1_nobypass", rd1_n, exp_rd(read_reg1, 1'b0));
            chk("model_rd2_nobypass", rd2_n, exp_rd(read_reg2, 1'b0));
        end
    end

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_write = 1'b1;
        write_reg = a;
        write_data = d;
        next();
        reg_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        reg_write = 1'b0;
        read_reg1 = 5'd29;
        read_reg2 = 5'd5;
        write_reg = 5'd0;
        write_data = 32'd0;
        #1 reset = 1'b0;
        #1;
        chk("reset_sp_rd1", rd1_b, 32'd227);
        chk("reset_r5_rd2", rd2_b, 32'd0);
        chk("reset_sp_rd1_nb", rd1_n, 32'd227);
        chk("reset_sp_model", m_regs[29], 32'd227);
        chk_en = 1;
        next();
        next();
        reset = 1'b1;
        next();

        wr(5'd8, 32'hDEADBEEF);
        write_data = 32'h1;
        read_reg1 = 5'd8;
        #1;
        chk("wr8_read", rd1_b, 32'hDEADBEEF);
        chk("wr8_read_nb", rd1_n, 32'hDEADBEEF);
        next();
        chk("wr8_hold", rd1_b, 32'hDEADBEEF);

        read_reg1 = 5'd0;
        read_reg2 = 5'd0;
        wr(5'd0, 32'hFFFFFFFF);
        #1;
        chk("r0_rd1", rd1_b, 32'd0);
        chk("r0_rd2", rd2_n, 32'd0);

        wr(5'd9, 32'h5);
        reg_write = 1'b1;
        write_reg = 5'd9;
        write_data = 32'hA;
        read_reg2 = 5'd9;
        #1;
        chk("bypass_on", rd2_b, 32'hA);
        chk("bypass_off_before", rd2_n, 32'h5);
        next();
        reg_write = 1'b0;
        #1;
        chk("bypass_off_after", rd2_n, 32'hA);

        wr(5'd31, 32'h400);
        wr(5'd29, 32'hE0);
        read_reg1 = 5'd31;
        read_reg2 = 5'd29;
        #1;
        chk("jal_r31", rd1_b, 32'h400);
        chk("sp_r29", rd2_b, 32'hE0);
        reset = 1'b0;
        #1;
        chk("reset_r31", rd1_b, 32'd0);
        chk("reset_r29", rd2_n, 32'd227);
        next();
        reset = 1'b1;

        wr(5'd3, 32'h7);
        reg_write = 1'b1;
        write_reg = 5'd3;
        write_data = 32'h9;
        read_reg1 = 5'd3;
        #1;
        chk("pre_reset_bypass", rd1_b, 32'h9);
        #1 reset = 1'b0;
        next();
        reset = 1'b1;
        reg_write = 1'b0;
        #1;
        chk("reset_mid_write", rd1_b, 32'd0);
        chk("reset_mid_write_nb", rd1_n, 32'd0);
        next();

        for (int c = 0; c < 3000; c++) begin
            logic [4:0] a;
            a = ($urandom_range(0, 3) == 0) ? 5'(29 + 2 * $urandom_range(0, 1))
                                             : 5'($urandom_range(0, 7));
            reg_write = ($urandom_range(0, 2) != 0);
            write_reg = a;
            write_data = $urandom;
            read_reg1 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
            read_reg2 = ($urandom_range(0, 3) == 0) ? read_reg1 : 5'($urandom_range(0, 31));
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 63) == 0) reset = 1'b0;
            next();
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
